// File: rtl/execute_stage_if.sv
// ID/EX -> EX -> EX/MEM bundle for the execute stage.
// master: the upstream/downstream pipeline side; slave: execute_stage itself.
interface execute_stage_if;
    logic        id_ex_valid;
    logic [3:0]  id_ex_aluop;
    logic        id_ex_alusrc;
    logic [31:0] id_ex_rega;
    logic [31:0] id_ex_regb;
    logic [31:0] id_ex_imm;
    logic        id_ex_readmem;
    logic        id_ex_writemem;
    logic        id_ex_selwsource;
    logic        id_ex_writereg;
    logic [4:0]  id_ex_regdest;
    logic        ex_flush;
    logic        ex_stall;
    logic        ex_mem_readmem;
    logic        ex_mem_writemem;
    logic        ex_mem_selwsource;
    logic        ex_mem_writereg;
    logic [4:0]  ex_mem_regdest;
    logic [31:0] ex_mem_regb;
    logic [31:0] ex_mem_wbvalue;

    modport master (
        output id_ex_valid, id_ex_aluop, id_ex_alusrc, id_ex_rega, id_ex_regb, id_ex_imm,
               id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_regdest,
               ex_flush,
        input  ex_stall, ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg,
               ex_mem_regdest, ex_mem_regb, ex_mem_wbvalue
    );

    modport slave (
        input  id_ex_valid, id_ex_aluop, id_ex_alusrc, id_ex_rega, id_ex_regb, id_ex_imm,
               id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg, id_ex_regdest,
               ex_flush,
        output ex_stall, ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg,
               ex_mem_regdest, ex_mem_regb, ex_mem_wbvalue
    );
endinterface

// File: rtl/execute_stage.sv
// Pipeline execute stage: single-cycle ALU plus iterative MUL (and DIV when
// EXECUTE_DIV_EN is defined), registering results into the EX/MEM outputs.
module execute_stage #(
    parameter int ITER_BITS = 1            // bits retired per busy cycle: 1, 2 or 4
) (
    input  logic           clock,
    input  logic           reset,
    execute_stage_if.slave ex
);
    localparam int N     = 32 / ITER_BITS;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_SLT = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                           OP_LUI = 4'd8, OP_MUL = 4'd9;
`ifdef EXECUTE_DIV_EN
    localparam logic [3:0] OP_DIV = 4'd10;
`endif

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic [31:0]      acc_reg, op_a_reg, op_b_reg;
    logic [31:0]      acc_next, op_a_next, op_b_next, mc_result;
    logic             cap_readmem_reg, cap_writemem_reg, cap_selwsource_reg, cap_writereg_reg;
    logic [4:0]       cap_regdest_reg;
    logic [31:0]      cap_regb_reg;
    logic [31:0]      op_b, alu_result;
    logic             start_multi;

    assign op_b = ex.id_ex_alusrc ? ex.id_ex_imm : ex.id_ex_regb;

    always_comb begin
        alu_result = 32'd0;
        case (ex.id_ex_aluop)
            OP_ADD:  alu_result = ex.id_ex_rega + op_b;
            OP_SUB:  alu_result = ex.id_ex_rega - op_b;
            OP_AND:  alu_result = ex.id_ex_rega & op_b;
            OP_OR:   alu_result = ex.id_ex_rega | op_b;
            OP_XOR:  alu_result = ex.id_ex_rega ^ op_b;
            OP_SLT:  alu_result = ($signed(ex.id_ex_rega) < $signed(op_b)) ? 32'd1 : 32'd0;
            OP_SLL:  alu_result = ex.id_ex_rega << op_b[4:0];
            OP_SRL:  alu_result = ex.id_ex_rega >> op_b[4:0];
            OP_LUI:  alu_result = op_b << 16;
            default: alu_result = 32'd0;
        endcase
    end

`ifdef EXECUTE_DIV_EN
    logic is_div_reg;
    assign start_multi = (ex.id_ex_aluop == OP_MUL) || (ex.id_ex_aluop == OP_DIV);
`else
    assign start_multi = (ex.id_ex_aluop == OP_MUL);
`endif

    // Shift-add multiplier: acc accumulates, op_a is the shifting multiplicand,
    // op_b the multiplier consumed LSB first.
    logic [31:0] mul_sum [ITER_BITS+1];
    assign mul_sum[0] = acc_reg;
    genvar gi;
    generate
        for (gi = 0; gi < ITER_BITS; gi++) begin : g_mul
            assign mul_sum[gi+1] = mul_sum[gi] + (op_b_reg[gi] ? (op_a_reg << gi) : 32'd0);
        end
    endgenerate

`ifdef EXECUTE_DIV_EN
    // Restoring divider: acc is the remainder, op_a shifts dividend out and
    // quotient in; a zero divisor naturally produces all-ones.
    logic [31:0] div_rem [ITER_BITS+1];
    logic [31:0] div_quo [ITER_BITS+1];
    assign div_rem[0] = acc_reg;
    assign div_quo[0] = op_a_reg;
    generate
        for (gi = 0; gi < ITER_BITS; gi++) begin : g_div
            logic [32:0] shifted;
            logic        ge;
            assign shifted        = {div_rem[gi], div_quo[gi][31]};
            assign ge             = shifted >= {1'b0, op_b_reg};
            assign div_rem[gi+1]  = ge ? 32'(shifted - {1'b0, op_b_reg}) : shifted[31:0];
            assign div_quo[gi+1]  = {div_quo[gi][30:0], ge};
        end
    endgenerate

    always_comb begin
        acc_next  = mul_sum[ITER_BITS];
        op_a_next = op_a_reg << ITER_BITS;
        op_b_next = op_b_reg >> ITER_BITS;
        mc_result = mul_sum[ITER_BITS];
        if (is_div_reg) begin
            acc_next  = div_rem[ITER_BITS];
            op_a_next = div_quo[ITER_BITS];
            op_b_next = op_b_reg;
            mc_result = div_quo[ITER_BITS];
        end
    end
`else
    always_comb begin
        acc_next  = mul_sum[ITER_BITS];
        op_a_next = op_a_reg << ITER_BITS;
        op_b_next = op_b_reg >> ITER_BITS;
        mc_result = mul_sum[ITER_BITS];
    end
`endif

    assign ex.ex_stall = !reset && !ex.ex_flush &&
                         ((state_reg == IDLE) ? (ex.id_ex_valid && start_multi)
                                              : (count_reg != LAST));

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= IDLE;
            count_reg          <= '0;
            acc_reg            <= '0;
            op_a_reg           <= '0;
            op_b_reg           <= '0;
            cap_readmem_reg    <= 1'b0;
            cap_writemem_reg   <= 1'b0;
            cap_selwsource_reg <= 1'b0;
            cap_writereg_reg   <= 1'b0;
            cap_regdest_reg    <= '0;
            cap_regb_reg       <= '0;
`ifdef EXECUTE_DIV_EN
            is_div_reg         <= 1'b0;
`endif
            ex.ex_mem_readmem    <= 1'b0;
            ex.ex_mem_writemem   <= 1'b0;
            ex.ex_mem_selwsource <= 1'b0;
            ex.ex_mem_writereg   <= 1'b0;
            ex.ex_mem_regdest    <= '0;
            ex.ex_mem_regb       <= '0;
            ex.ex_mem_wbvalue    <= '0;
        end else begin
            // Bubble unless a branch below produces a real result.
            ex.ex_mem_readmem    <= 1'b0;
            ex.ex_mem_writemem   <= 1'b0;
            ex.ex_mem_selwsource <= 1'b0;
            ex.ex_mem_writereg   <= 1'b0;
            ex.ex_mem_regdest    <= '0;
            ex.ex_mem_regb       <= '0;
            ex.ex_mem_wbvalue    <= '0;
            if (ex.ex_flush) begin
                state_reg <= IDLE;
                count_reg <= '0;
            end else if (state_reg == IDLE) begin
                if (ex.id_ex_valid && start_multi) begin
                    state_reg          <= BUSY;
                    count_reg          <= '0;
                    acc_reg            <= '0;
                    op_a_reg           <= ex.id_ex_rega;
                    op_b_reg           <= op_b;
                    cap_readmem_reg    <= ex.id_ex_readmem;
                    cap_writemem_reg   <= ex.id_ex_writemem;
                    cap_selwsource_reg <= ex.id_ex_selwsource;
                    cap_writereg_reg   <= ex.id_ex_writereg;
                    cap_regdest_reg    <= ex.id_ex_regdest;
                    cap_regb_reg       <= ex.id_ex_regb;
`ifdef EXECUTE_DIV_EN
                    is_div_reg         <= (ex.id_ex_aluop == OP_DIV);
`endif
                end else if (ex.id_ex_valid) begin
                    ex.ex_mem_readmem    <= ex.id_ex_readmem;
                    ex.ex_mem_writemem   <= ex.id_ex_writemem;
                    ex.ex_mem_selwsource <= ex.id_ex_selwsource;
                    ex.ex_mem_writereg   <= ex.id_ex_writereg;
                    ex.ex_mem_regdest    <= ex.id_ex_regdest;
                    ex.ex_mem_regb       <= ex.id_ex_regb;
                    ex.ex_mem_wbvalue    <= alu_result;
                end
            end else begin
                acc_reg   <= acc_next;
                op_a_reg  <= op_a_next;
                op_b_reg  <= op_b_next;
                count_reg <= count_reg + CNT_W'(1);
                if (count_reg == LAST) begin
                    state_reg            <= IDLE;
                    count_reg            <= '0;
                    ex.ex_mem_readmem    <= cap_readmem_reg;
                    ex.ex_mem_writemem   <= cap_writemem_reg;
                    ex.ex_mem_selwsource <= cap_selwsource_reg;
                    ex.ex_mem_writereg   <= cap_writereg_reg;
                    ex.ex_mem_regdest    <= cap_regdest_reg;
                    ex.ex_mem_regb       <= cap_regb_reg;
                    ex.ex_mem_wbvalue    <= mc_result;
                end
            end
        end
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Pipeline Execute stage: takes decoded operands/controls from ID/EX and computes the ALU result.
- Registers the result plus memory/writeback controls into the EX/MEM outputs consumed by the Memory stage.
- Single-cycle ALU ops; iterative multi-cycle MUL (and optional DIV) that stalls upstream via ex_stall.
- Inserts bubbles on the EX/MEM outputs while a multi-cycle op is busy.

Parameters:
- ITER_BITS, 1: multiplier/divider bits retired per cycle; legal 1, 2, 4. Multi-cycle latency N = 32/ITER_BITS.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- id_ex_valid  in  1  instruction present on id_ex_* inputs
- id_ex_aluop  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed), 6 SLL, 7 SRL, 8 LUI, 9 MUL, 10 DIV; 11-15 give result 0
- id_ex_alusrc  in  1  1: operand B = id_ex_imm; 0: operand B = id_ex_regb
- id_ex_rega  in  32  operand A
- id_ex_regb  in  32  register B (also store data)
- id_ex_imm  in  32  sign-extended immediate
- id_ex_readmem, id_ex_writemem, id_ex_selwsource, id_ex_writereg  in  1 each  controls passed to Memory
- id_ex_regdest  in  5  destination register
- ex_flush  in  1  kill the current/in-flight instruction
- ex_stall  out  1  combinational; upstream holds id_ex_* stable while high
- ex_mem_readmem, ex_mem_writemem, ex_mem_selwsource, ex_mem_writereg  out  1 each  registered controls
- ex_mem_regdest  out  5  registered destination register
- ex_mem_regb  out  32  registered store data (id_ex_regb)
- ex_mem_wbvalue  out  32  registered ALU result / memory address

Behaviour:
- Reset: all ex_mem_* = 0, FSM = IDLE, counter = 0, ex_stall = 0.
- Bubble: ex_mem_readmem, writemem and writereg = 0; other outputs = 0.
- Single-cycle ops, IDLE with valid: result and controls registered at the next edge (latency 1).
- IDLE with !valid: bubble registered.
- Arithmetic: 32-bit wrap-around; SLT yields 1/0.
- SLL/SRL shift amount = opB[4:0], logical.
- LUI result = opB << 16.
- MUL result = low 32 bits of the unsigned product.
- DIV: unsigned restoring division, quotient only; divisor 0 gives 0xFFFFFFFF.
- FSM: IDLE, BUSY.
- Cycle t, IDLE, valid MUL/DIV:
  - ex_stall = 1.
  - Edge: capture operands and controls, counter = 0, FSM -> BUSY, bubble registered.
- BUSY:
  - ITER_BITS bits processed per cycle; counter increments.
  - ex_stall = 1 while counter < N-1.
  - id_ex_* are ignored.
  - Bubble registered each edge except the last.
- Last BUSY cycle (counter = N-1, cycle t+N):
  - ex_stall = 0, so upstream advances at this edge.
  - Edge writes the result and captured controls to ex_mem_*; FSM -> IDLE.
- Cycle t+N+1: next instruction accepted normally.
- Back-to-back MULs: the second starts at t+N+1.
- ex_flush has priority over everything:
  - ex_stall = 0 combinationally.
  - Bubble registered at the edge; FSM -> IDLE; partial result discarded.
- reset has priority over ex_flush. Reset mid-BUSY aborts the op; no result is written.
- valid held low during BUSY has no effect.

Optional Feature:
- Macro: EXECUTE_DIV_EN.
- Defined: aluop 10 runs the iterative divider (N cycles, stall and BUSY rules as for MUL).
- Undefined: aluop 10 is single-cycle, result 0, no stall; divider logic absent.

Test Plan:
- Reset held 2 cycles, then ADD rega=5, imm=7, alusrc=1, writereg=1, regdest=3 -> next edge wbvalue=12, writereg=1, regdest=3, ex_stall=0.
- Store: writemem=1, rega=0x100, imm=4, regb=0xDEADBEEF -> wbvalue=0x104, ex_mem_regb=0xDEADBEEF, writemem=1.
- MUL 0x10000 * 0x30000 with ITER_BITS=1 -> ex_stall high exactly 32 cycles, 32 bubbles, then wbvalue=0x00000000; MUL 7*6 -> 42.
- ex_flush asserted in BUSY cycle 10 of a MUL -> next edge bubble, ex_stall=0, FSM IDLE; a following ADD completes normally.
- With EXECUTE_DIV_EN: DIV 100/7 -> 14 after 32 stall cycles; DIV 5/0 -> 0xFFFFFFFF. Without: DIV gives 0, no stall.
- SLT -1 vs 1 -> 1; SRL 0x80000000 by 31 -> 1; aluop 13 -> 0.
